pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (F, D, EXE, MEM, WB) whose decode stage resolves branches and forwards ALU results from EXE and MEM. It tracks the destination registers and load flags of the instructions in EXE and MEM in internal shadow registers. From these it generates the stall, flush and bubble controls for the pipeline registers. It also freezes the pipeline while data memory is not ready, with a timeout into a sticky error state, and keeps a saturating stall-cycle counter.

## Interface
- `WAIT_MAX`, 16: maximum consecutive memory-freeze cycles before ERROR (≥2).
- `CNT_W`, 16: width of the stall-cycle counter.

- `clk` in 1: processor clock. One clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_D` in 1: D holds a real instruction (0 = bubble).
- `rs1_D`, `rs2_D` in 5: source register addresses of the instruction in D.
- `use_rs1_D`, `use_rs2_D` in 1: the instruction in D reads that source.
- `rd_D` in 5: destination of the instruction in D.
- `reg_write_D` in 1: the instruction in D writes `rd_D`.
- `mem_read_D` in 1: the instruction in D is a load.
- `Select_PC` in 1: branch taken, resolved in D.
- `mem_req` in 1: the MEM-stage instruction accesses data memory this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `stall_F` out 1: hold PC.
- `stall_D` out 1: hold the IF/ID register.
- `flush_D` out 1: load a bubble into IF/ID at the next edge.
- `bubble_E` out 1: load a bubble into ID/EX at the next edge.
- `stall_E` out 1: hold ID/EX and EX/MEM.
- `stall_M` out 1: hold MEM/WB and suppress the WB register write.
- `ctrl_state` out 2: RUN=00, WAIT=01, ERROR=11.
- `error` out 1: high in ERROR.
- `stall_cycles` out CNT_W: saturating count of cycles with `stall_F`=1.

## Operation
- Shadow registers `ex_rd`, `ex_we`, `ex_load`, `mem_rd`, `mem_we`, `mem_load` mirror ID/EX and EX/MEM.
- Shadow update on each edge:
  - `freeze`=1: all shadow registers hold.
  - Otherwise: MEM copy ← EX copy.
  - EX copy ← D fields, or zeros if `bubble_E` or `!valid_D`.
- Load-use hazard `luh` is asserted when `valid_D` and, for some used source `rsX_D` with `rsX_D` ≠ 0, either:
  - `ex_load && ex_we && ex_rd == rsX_D`, or
  - `mem_load && mem_we && mem_rd == rsX_D`.
- Load data is consumable in D once the load reaches WB through register-file write-through, so WB never raises a hazard.
- ALU-result dependencies never stall because the EXE and MEM forwarding paths cover them.
- `freeze` = `(mem_req && !mem_ready)` or state == ERROR.
- Output priority is freeze > luh > branch:
  - freeze: `stall_F`=`stall_D`=`stall_E`=`stall_M`=1; `flush_D`=`bubble_E`=0.
  - luh, no freeze: `stall_F`=`stall_D`=1 and `bubble_E`=1. `flush_D`=0, so `Select_PC` is ignored because branch operands are not yet valid.
  - `Select_PC && valid_D`, no freeze, no luh: `flush_D`=1, killing the fall-through instruction fetched alongside the branch.
  - Otherwise all controls are 0.
- FSM:
  - RUN → WAIT on a freeze cycle.
  - WAIT → RUN on the first cycle with `mem_ready` (or `!mem_req`). That cycle is not frozen, and the pipeline advances.
  - WAIT → ERROR when `wait_cnt` == WAIT_MAX−1 and the cycle is still frozen.
  - ERROR is left only by `reset`.
- `wait_cnt` (width clog2(WAIT_MAX)): increments on every freeze cycle in RUN/WAIT and clears on any non-frozen cycle.
- `stall_cycles`: +1 per cycle with `stall_F`=1, saturating at all-ones with no wrap. It still counts in ERROR.

## Timing
- All stall/flush/bubble outputs are combinational from the inputs and current state; there is no added latency.
- Reset values, effective after the edge with `reset`=1:
  - State RUN, `error`=0, `stall_cycles`=0, `wait_cnt`=0, all shadow registers 0.
  - Outputs are therefore all 0 unless the inputs request otherwise.
- Load immediately followed by a dependent instruction: 2 stall cycles. Load with one instruction between: 1 stall cycle.
- A freeze arising during a load-use stall takes priority: the shadow state holds, and the luh stall resumes after the freeze ends.
- `reset` during WAIT or ERROR takes effect on that edge regardless of `mem_ready`.
- `rs`=x0 never stalls.

## Test plan
- Load `x5` in D, then `add x6,x5,x1`: `stall_F`/`stall_D`/`bubble_E`=1 for exactly 2 cycles, then 0; `stall_cycles`=2.
- Load `x5`, then independent instruction, then `beq x5,x0`: 1 stall cycle, then `Select_PC`=1 gives `flush_D`=1 for 1 cycle.
- Load `x0` followed by a use of `x0`: no stall. ALU write of `x7` followed by a use of `x7`: no stall.
- `mem_req`=1, `mem_ready`=0 for 3 cycles then 1: all four stalls high for 3 cycles, `ctrl_state`=WAIT for cycles 2–4, RUN afterwards, `error`=0.
- WAIT_MAX=16, `mem_ready` held 0: ERROR entered on the edge ending freeze cycle 16; `error` stays 1 after `mem_ready`=1; `reset` clears it.
- `Select_PC`=1 concurrent with luh: `flush_D`=0. The same with freeze: `flush_D`=0 and `bubble_E`=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: load-use stalls, branch flush,
// memory-wait freeze with timeout into a sticky error state, and a saturating stall counter.
module pipeline_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_D,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic             use_rs1_D,
    input  logic             use_rs2_D,
    input  logic [4:0]       rd_D,
    input  logic             reg_write_D,
    input  logic             mem_read_D,
    input  logic             Select_PC,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             bubble_E,
    output logic             stall_E,
    output logic             stall_M,
    output logic [1:0]       ctrl_state,
    output logic             error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCW = $clog2(WAIT_MAX);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] ex_rd_q, ex_rd_d;
    logic       ex_we_q, ex_we_d;
    logic       ex_load_q, ex_load_d;
    logic [4:0] mem_rd_q, mem_rd_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_load_q, mem_load_d;

    logic freeze;
    logic hit1, hit2, luh;

    assign freeze = (mem_req && !mem_ready) || (state_q == ST_ERROR);

    // Only loads still in EX or MEM stall; WB data reaches D through the register file.
    assign hit1 = use_rs1_D && (rs1_D != 5'd0) &&
                  ((ex_load_q  && ex_we_q  && (ex_rd_q  == rs1_D)) ||
                   (mem_load_q && mem_we_q && (mem_rd_q == rs1_D)));
    assign hit2 = use_rs2_D && (rs2_D != 5'd0) &&
                  ((ex_load_q  && ex_we_q  && (ex_rd_q  == rs2_D)) ||
                   (mem_load_q && mem_we_q && (mem_rd_q == rs2_D)));
    assign luh  = valid_D && (hit1 || hit2);

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        flush_D  = 1'b0;
        bubble_E = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        if (freeze) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
        end else if (luh) begin
            // Branch operands are stale during a load-use stall, so Select_PC is ignored.
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            bubble_E = 1'b1;
        end else if (Select_PC && valid_D) begin
            flush_D = 1'b1;
        end
    end

    always_comb begin
        ex_rd_d    = ex_rd_q;
        ex_we_d    = ex_we_q;
        ex_load_d  = ex_load_q;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        mem_load_d = mem_load_q;
        if (!freeze) begin
            mem_rd_d   = ex_rd_q;
            mem_we_d   = ex_we_q;
            mem_load_d = ex_load_q;
            if (bubble_E || !valid_D) begin
                ex_rd_d   = 5'd0;
                ex_we_d   = 1'b0;
                ex_load_d = 1'b0;
            end else begin
                ex_rd_d   = rd_D;
                ex_we_d   = reg_write_D;
                ex_load_d = mem_read_D;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (freeze) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    assign cnt_d = (stall_F && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            ex_rd_q    <= 5'd0;
            ex_we_q    <= 1'b0;
            ex_load_q  <= 1'b0;
            mem_rd_q   <= 5'd0;
            mem_we_q   <= 1'b0;
            mem_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_q      <= cnt_d;
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ex_load_q  <= ex_load_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            mem_load_q <= mem_load_d;
        end
    end

    assign ctrl_state   = state_q;
    assign error        = (state_q == ST_ERROR);
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, hand-written freeze/timeout
// sequences, and randomized traffic against a stage-list reference model.
module tb_pipeline_hazard_ctrl;

    localparam int WAIT_MAX = 16;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic valid_D, use_rs1_D, use_rs2_D, reg_write_D, mem_read_D, Select_PC, mem_req, mem_ready;
    logic [4:0] rs1_D, rs2_D, rd_D;
    logic stall_F, stall_D, flush_D, bubble_E, stall_E, stall_M, error;
    logic [1:0] ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D), .rd_D(rd_D), .reg_write_D(reg_write_D),
        .mem_read_D(mem_read_D), .Select_PC(Select_PC), .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .bubble_E(bubble_E),
        .stall_E(stall_E), .stall_M(stall_M), .ctrl_state(ctrl_state), .error(error),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we, ld, sel, mreq, mrdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [8:0] exp;
        int         cnt;
    } vec_t;

    // {stall_F, stall_D, flush_D, bubble_E, stall_E, stall_M}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LUH  = 6'b110100;
    localparam logic [5:0] C_FLU  = 6'b001000;
    localparam logic [5:0] C_FRZ  = 6'b110011;
    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_ERR  = 2'b11;

    function automatic in_t IN(bit v, int rs1, bit u1, int rs2, bit u2, int rd,
                               bit we, bit ld, bit sel, bit mreq, bit mrdy);
        in_t x;
        x.v = v; x.rs1 = 5'(rs1); x.u1 = u1; x.rs2 = 5'(rs2); x.u2 = u2; x.rd = 5'(rd);
        x.we = we; x.ld = ld; x.sel = sel; x.mreq = mreq; x.mrdy = mrdy;
        return x;
    endfunction

    function automatic vec_t R(in_t x, logic [5:0] c, logic [1:0] st, int cnt);
        vec_t r;
        r.i = x; r.exp = {c, st, 1'b0}; r.cnt = cnt;
        return r;
    endfunction

    // Reference model: list of instructions occupying EX (0) and MEM (1),
    // count of consecutive frozen cycles, sticky error flag, saturating stall count.
    typedef struct { bit ld; bit we; int rd; } stg_t;
    stg_t m_stg [2];
    int   m_run;
    bit   m_err;
    int   m_cnt;

    function automatic bit model_luh(in_t x);
        if (!x.v) return 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (m_stg[s].ld && m_stg[s].we) begin
                if (x.u1 && x.rs1 != 0 && int'(x.rs1) == m_stg[s].rd) return 1'b1;
                if (x.u2 && x.rs2 != 0 && int'(x.rs2) == m_stg[s].rd) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [8:0] model_out(in_t x);
        bit frz;
        logic [5:0] c;
        logic [1:0] st;
        frz = (x.mreq && !x.mrdy) || m_err;
        if (frz) c = C_FRZ;
        else if (model_luh(x)) c = C_LUH;
        else if (x.sel && x.v) c = C_FLU;
        else c = C_NONE;
        st = m_err ? S_ERR : (m_run > 0 ? S_WAIT : S_RUN);
        return {c, st, m_err};
    endfunction

    task automatic model_step(in_t x, bit rst);
        bit frz, luh;
        if (rst) begin
            m_run = 0; m_err = 0; m_cnt = 0;
            for (int s = 0; s < 2; s++) m_stg[s] = '{ld: 0, we: 0, rd: 0};
            return;
        end
        frz = (x.mreq && !x.mrdy) || m_err;
        luh = model_luh(x);
        if ((frz || luh) && m_cnt < CNT_MAX) m_cnt++;
        if (!frz) begin
            m_stg[1] = m_stg[0];
            if (luh || !x.v) m_stg[0] = '{ld: 0, we: 0, rd: 0};
            else m_stg[0] = '{ld: x.ld, we: x.we, rd: int'(x.rd)};
        end
        if (!m_err) begin
            if (frz) begin
                m_run++;
                if (m_run == WAIT_MAX) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic drive(in_t x);
        valid_D = x.v; rs1_D = x.rs1; rs2_D = x.rs2; use_rs1_D = x.u1; use_rs2_D = x.u2;
        rd_D = x.rd; reg_write_D = x.we; mem_read_D = x.ld; Select_PC = x.sel;
        mem_req = x.mreq; mem_ready = x.mrdy;
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(string nm, in_t x, bit rst, logic [8:0] exp, int ecnt);
        logic [8:0] got;
        drive(x);
        reset = rst;
        #3;
        got = {stall_F, stall_D, flush_D, bubble_E, stall_E, stall_M, ctrl_state, error};
        checks++;
        if (got !== exp || stall_cycles !== CNT_W'(ecnt)) begin
            failures++;
            $display("FAIL %s ctl_st_err=%b cnt=%0d required ctl_st_err=%b cnt=%0d",
                     nm, got, stall_cycles, exp, ecnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        drive(IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_step(IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1);
    endtask

    vec_t tbl [18];
    in_t  idle, frz_in, add_x5, beq_x5, use_x9;

    initial begin
        idle   = IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        frz_in = IN(1, 3, 1, 0, 0, 4, 1, 0, 1, 1, 0);
        add_x5 = IN(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1);
        beq_x5 = IN(1, 5, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        use_x9 = IN(1, 9, 1, 0, 0, 10, 1, 0, 1, 0, 1);

        // Load x5 then dependent add: two stall cycles.
        tbl[0]  = R(IN(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1), C_NONE, S_RUN, 0);
        tbl[1]  = R(add_x5, C_LUH,  S_RUN, 0);
        tbl[2]  = R(add_x5, C_LUH,  S_RUN, 1);
        tbl[3]  = R(add_x5, C_NONE, S_RUN, 2);
        // Load x5, independent op, beq x5: one stall (branch ignored), then flush.
        tbl[4]  = R(IN(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 1), C_NONE, S_RUN, 2);
        tbl[5]  = R(IN(1, 1, 1, 0, 0, 7, 1, 0, 0, 0, 1), C_NONE, S_RUN, 2);
        tbl[6]  = R(beq_x5, C_LUH,  S_RUN, 2);
        tbl[7]  = R(beq_x5, C_FLU,  S_RUN, 3);
        tbl[8]  = R(idle,   C_NONE, S_RUN, 3);
        // x0 never stalls; ALU results never stall.
        tbl[9]  = R(IN(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), C_NONE, S_RUN, 3);
        tbl[10] = R(IN(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1), C_NONE, S_RUN, 3);
        tbl[11] = R(IN(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1), C_NONE, S_RUN, 3);
        tbl[12] = R(IN(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 1), C_NONE, S_RUN, 3);
        // Freeze on top of a load-use stall with a taken branch; luh resumes afterwards.
        tbl[13] = R(IN(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1), C_NONE, S_RUN, 3);
        tbl[14] = R(IN(1, 9, 1, 0, 0, 10, 1, 0, 1, 1, 0), C_FRZ, S_RUN, 3);
        tbl[15] = R(IN(1, 9, 1, 0, 0, 10, 1, 0, 1, 1, 1), C_LUH, S_WAIT, 4);
        tbl[16] = R(use_x9, C_LUH, S_RUN, 5);
        tbl[17] = R(use_x9, C_FLU, S_RUN, 6);

        reset = 1'b1;
        drive(idle);
        @(posedge clk);
        #1;
        reset = 1'b0;

        cyc("reset_state", idle, 1'b0, {C_NONE, S_RUN, 1'b0}, 0);
        for (int n = 0; n < 18; n++)
            cyc($sformatf("tbl%0d", n), tbl[n].i, 1'b0, tbl[n].exp, tbl[n].cnt);

        // Three-cycle memory wait, then reset while in WAIT.
        do_reset();
        for (int k = 1; k <= 3; k++)
            cyc($sformatf("wait3_c%0d", k), IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0,
                {C_FRZ, (k == 1) ? S_RUN : S_WAIT, 1'b0}, k - 1);
        cyc("wait3_ready", IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0, {C_NONE, S_WAIT, 1'b0}, 3);
        cyc("wait3_after", idle, 1'b0, {C_NONE, S_RUN, 1'b0}, 3);
        cyc("wait_again", IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, {C_FRZ, S_RUN, 1'b0}, 3);
        cyc("rst_in_wait", IN(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, {C_FRZ, S_WAIT, 1'b0}, 4);
        cyc("after_rst_wait", idle, 1'b0, {C_NONE, S_RUN, 1'b0}, 0);

        // Timeout into ERROR, counter saturation, reset out of ERROR.
        do_reset();
        for (int k = 1; k <= WAIT_MAX; k++)
            cyc($sformatf("tmo_c%0d", k), frz_in, 1'b0,
                {C_FRZ, (k == 1) ? S_RUN : S_WAIT, 1'b0}, k - 1);
        cyc("err_ready", IN(1, 3, 1, 0, 0, 4, 1, 0, 1, 1, 1), 1'b0, {C_FRZ, S_ERR, 1'b1}, WAIT_MAX);
        for (int k = WAIT_MAX + 2; k <= 90; k++)
            cyc($sformatf("err_hold%0d", k), idle, 1'b0, {C_FRZ, S_ERR, 1'b1},
                (k - 1 > CNT_MAX) ? CNT_MAX : k - 1);
        cyc("rst_in_err", frz_in, 1'b1, {C_FRZ, S_ERR, 1'b1}, CNT_MAX);
        cyc("after_rst_err", idle, 1'b0, {C_NONE, S_RUN, 1'b0}, 0);

        // Randomized traffic against the reference model.
        do_reset();
        begin
            int burst = 0;
            for (int n = 0; n < 3000; n++) begin
                in_t x;
                bit  rst;
                x.v    = ($urandom_range(0, 99) < 85);
                x.rs1  = 5'($urandom_range(0, 7));
                x.rs2  = 5'($urandom_range(0, 7));
                x.u1   = 1'($urandom_range(0, 1));
                x.u2   = 1'($urandom_range(0, 1));
                x.rd   = 5'($urandom_range(0, 7));
                x.we   = ($urandom_range(0, 99) < 70);
                x.ld   = ($urandom_range(0, 99) < 35);
                x.sel  = ($urandom_range(0, 99) < 15);
                if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(12, 20);
                if (burst > 0) begin
                    x.mreq = 1'b1;
                    x.mrdy = 1'b0;
                    burst--;
                end else begin
                    x.mreq = ($urandom_range(0, 99) < 30);
                    x.mrdy = ($urandom_range(0, 1) == 1);
                end
                rst = ($urandom_range(0, 149) == 0);
                cyc($sformatf("rand%0d", n), x, rst, model_out(x), m_cnt);
                model_step(x, rst);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
